// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready channel feeding the instruction memory loader.
interface imem_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    modport master(output rx_valid, rx_data, input rx_ready);
    modport slave(input rx_valid, rx_data, output rx_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into word memory, holds the core in reset until done, then serves instrF.
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    imem_loader_if.slave       rx,
    input  logic               reload,
    input  logic [31:0]        pcF,
    output logic [31:0]        instrF,
    output logic               core_rst_n,
    output logic               load_done,
    output logic               load_err,
    output logic [ADDR_W:0]    word_count
);
    typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_RUN, S_ERR} state_t;
    state_t             state, stateNext;
    logic [15:0]        lenReg, lenFull;
    logic [1:0]         byteIdx;
    logic [23:0]        asmReg;
    logic [31:0]        mem [2**ADDR_W];
    logic               xfer, restart, lenBad, memWe;
    logic [ADDR_W:0]    wordInc;
    logic [ADDR_W-1:0]  rdIdx;
    assign rx.rx_ready = state inside {S_LEN0, S_LEN1, S_DATA};
    assign load_done   = state == S_RUN;
    assign load_err    = state == S_ERR;
    assign xfer        = rx.rx_valid & rx.rx_ready;
    assign restart     = reload && state != S_LEN0;
    assign lenFull     = {rx.rx_data, lenReg[7:0]};
    assign lenBad      = lenFull == 16'd0 || 32'(lenFull) > (32'd1 << ADDR_W);
    assign wordInc     = word_count + (ADDR_W+1)'(1);
    assign memWe       = xfer && !restart && state == S_DATA && byteIdx == 2'd3;
    assign rdIdx       = pcF[ADDR_W+1:2];
    // Whole-pcF shift covers the upper-bits range check; the byte offset is simply dropped.
    assign instrF      = (state == S_RUN && (pcF >> (ADDR_W+2)) == 32'd0 && {1'b0, rdIdx} < word_count)
                         ? mem[rdIdx] : NOP_INSTR;
    always_comb begin
        stateNext = state;
        if (restart) stateNext = S_LEN0;
        else if (xfer)
            case (state)
                S_LEN0:  stateNext = S_LEN1;
                S_LEN1:  stateNext = lenBad ? S_ERR : S_DATA;
                S_DATA:  stateNext = (byteIdx == 2'd3 && 32'(wordInc) == 32'(lenReg)) ? S_RUN : S_DATA;
                default: stateNext = state;
            endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= S_LEN0;
            lenReg     <= '0;
            byteIdx    <= '0;
            asmReg     <= '0;
            word_count <= '0;
            core_rst_n <= 1'b0;
        end else begin
            state      <= stateNext;
            core_rst_n <= stateNext == S_RUN;
            if (restart) begin
                byteIdx    <= '0;
                word_count <= '0;
            end else if (xfer)
                case (state)
                    S_LEN0: lenReg[7:0] <= rx.rx_data;
                    S_LEN1: begin
                        lenReg[15:8] <= rx.rx_data;
                        if (!lenBad) begin
                            word_count <= '0;
                            byteIdx    <= '0;
                        end
                    end
                    S_DATA: begin
                        byteIdx <= byteIdx + 2'd1;
                        // Bytes shift in from the top so lanes 0..2 line up under the final byte.
                        if (byteIdx == 2'd3) word_count <= wordInc;
                        else asmReg <= {rx.rx_data, asmReg[23:8]};
                    end
                    default: ;
                endcase
        end
    always_ff @(posedge clk)
        if (memWe) mem[word_count[ADDR_W-1:0]] <= {rx.rx_data, asmReg};
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream bench; expectations come from the accepted-byte history since the last restart.
module tb_imem_loader;
    localparam logic [31:0] NOP = 32'h00000013;
    logic        clk = 1'b0, rst = 1'b1, reload = 1'b0;
    logic [31:0] pcF = '0, instrF;
    logic        core_rst_n, load_done, load_err;
    logic [8:0]  word_count;
    int          checks = 0, errors = 0;
    logic [7:0]  q[$];
    imem_loader_if rx();
    imem_loader dut(.clk(clk), .rst(rst), .rx(rx), .reload(reload), .pcF(pcF), .instrF(instrF),
                    .core_rst_n(core_rst_n), .load_done(load_done), .load_err(load_err), .word_count(word_count));
    always #5 clk = ~clk;
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic int lenOf();
        return q.size() >= 2 ? int'({q[1], q[0]}) : 0;
    endfunction
    function automatic bit isErr();
        return q.size() >= 2 && (lenOf() == 0 || lenOf() > 256);
    endfunction
    function automatic bit isDone();
        return q.size() >= 2 && !isErr() && q.size() == 2 + 4 * lenOf();
    endfunction
    function automatic int expWc();
        return (q.size() < 2 || isErr()) ? 0 : (q.size() - 2) / 4;
    endfunction
    function automatic logic [31:0] expInstr(input logic [31:0] pc);
        int i;
        i = int'(pc >> 2);
        if (!isDone() || pc >= 32'h400 || i >= lenOf()) return NOP;
        return {q[5+4*i], q[4+4*i], q[3+4*i], q[2+4*i]};
    endfunction
    task automatic checkAll();
        checkVal("rx_ready", 32'(rx.rx_ready), 32'(!(isErr() || isDone())));
        checkVal("load_done", 32'(load_done), 32'(isDone()));
        checkVal("load_err", 32'(load_err), 32'(isErr()));
        checkVal("core_rst_n", 32'(core_rst_n), 32'(isDone()));
        checkVal("word_count", 32'(word_count), 32'(expWc()));
        checkVal("instrF", instrF, expInstr(pcF));
    endtask
    task automatic step(input logic v, input logic [7:0] d, input logic rl);
        bit acc, rlEff;
        @(negedge clk);
        rx.rx_valid = v;
        rx.rx_data  = d;
        reload      = rl;
        pcF         = $urandom_range(0, 32'h420);
        #1;
        checkAll();
        acc   = v && !(isErr() || isDone());
        rlEff = rl && q.size() != 0;
        @(posedge clk);
        if (rlEff) q.delete();
        else if (acc) q.push_back(d);
    endtask
    task automatic sendByte(input logic [7:0] d, input bit jitter);
        if (jitter) repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom), 1'b0);
        step(1'b1, d, 1'b0);
    endtask
    task automatic probe(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        @(negedge clk);
        rx.rx_valid = 1'b0;
        reload      = 1'b0;
        pcF         = pc;
        #1;
        checkVal(tag, instrF, exp);
        checkVal({tag, "_model"}, instrF, expInstr(pc));
    endtask
    initial begin
        logic [7:0] prog[10];
        prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
        rx.rx_valid = 1'b0;
        rx.rx_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        checkAll();
        rst = 1'b0;
        foreach (prog[i]) sendByte(prog[i], 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checkVal("wc_two", 32'(word_count), 32'd2);
        probe("pc0", 32'h0, 32'h00A00513);
        probe("pc4", 32'h4, 32'h00500593);
        probe("pc8", 32'h8, NOP);
        step(1'b0, 8'h00, 1'b1);
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checkVal("err_zero", 32'(load_err), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        checkVal("ready_after_reload", 32'(rx.rx_ready), 32'd1);
        sendByte(8'h01, 1'b0);
        sendByte(8'h01, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checkVal("err_257", 32'(load_err), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        sendByte(8'h00, 1'b0);
        sendByte(8'h01, 1'b0);
        repeat (1024) sendByte(8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checkVal("wc_full", 32'(word_count), 32'd256);
        probe("pc_last", 32'h3FC, {q[1025], q[1024], q[1023], q[1022]});
        probe("pc_over", 32'h400, NOP);
        probe("pc_high", 32'h8000_0000, NOP);
        step(1'b0, 8'h00, 1'b1);
        sendByte(8'h03, 1'b1);
        sendByte(8'h00, 1'b1);
        repeat (12) sendByte(8'($urandom), 1'b1);
        step(1'b0, 8'h00, 1'b0);
        checkVal("wc_jitter", 32'(word_count), 32'd3);
        for (int i = 0; i < 4; i++) probe("pc_jitter", 32'(4 * i + $urandom_range(0, 3)), i < 3 ? {q[5+4*i], q[4+4*i], q[3+4*i], q[2+4*i]} : NOP);
        step(1'b0, 8'h00, 1'b1);
        sendByte(8'h02, 1'b0);
        sendByte(8'h00, 1'b0);
        repeat (6) sendByte(8'($urandom), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        checkVal("wc_reload", 32'(word_count), 32'd0);
        checkVal("crn_reload", 32'(core_rst_n), 32'd0);
        sendByte(8'h01, 1'b0);
        sendByte(8'h00, 1'b0);
        repeat (4) sendByte(8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checkVal("wc_one", 32'(word_count), 32'd1);
        probe("pc_one", 32'h0, {q[5], q[4], q[3], q[2]});
        #1 rst = 1'b1;
        #1;
        checkVal("async_crn", 32'(core_rst_n), 32'd0);
        checkVal("async_instr", instrF, NOP);
        checkVal("async_done", 32'(load_done), 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time instruction memory and loader that sits directly upstream of the pipeline's fetch stage.
- Receives a length-prefixed byte stream on a valid/ready port and assembles it into little-endian 32-bit words in an internal word array.
- Holds the core in reset while loading, then releases it and serves instrF combinationally from the core's pcF.

Parameters:
- ADDR_W, 8, word-address width; array depth is 2**ADDR_W words.
- NOP_INSTR, 32'h00000013, instruction returned when no valid program word is available (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- rx_valid  input  1  a byte is presented on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid & rx_ready at the clock edge.
- reload  input  1  single-cycle pulse; restarts loading from any state except S_LEN0.
- pcF  input  32  core fetch PC.
- instrF  output  32  instruction for pcF, combinational.
- core_rst_n  output  1  active-low reset to the core, registered.
- load_done  output  1  high while in S_RUN.
- load_err  output  1  sticky error flag, high while in S_ERR.
- word_count  output  ADDR_W+1  number of words loaded in the current or last load.

Behaviour:
- Reset is asynchronous and active-high; no other reset exists.
- Reset values:
  - State S_LEN0.
  - rx_ready=1, core_rst_n=0, load_done=0, load_err=0, word_count=0.
  - Byte index and length register cleared.
  - Array contents are not reset.
- States:
  - S_LEN0: on a transfer, capture len[7:0] and go to S_LEN1.
  - S_LEN1: on a transfer, capture len[15:8]. If len==0 or len>2**ADDR_W, go to S_ERR. Otherwise go to S_DATA and clear word_count and the byte index.
  - S_DATA: each transfer writes rx_data into byte lane byte_idx (0..3) of the assembly register.
    - When the transfer has byte_idx==3, the full word {rx_data, b2, b1, b0} is written at mem[word_count], word_count increments, and byte_idx wraps to 0.
    - When the incremented word_count equals len, go to S_RUN on the same edge.
  - S_RUN: rx_ready=0, load_done=1, core_rst_n=1 from the first cycle in S_RUN (registered).
  - S_ERR: rx_ready=0, load_err=1, core_rst_n=0. Exit only via rst or reload.
- rx_ready is 1 in S_LEN0/S_LEN1/S_DATA and 0 in S_RUN/S_ERR. No back-pressure is applied in the loading states, so a byte can be accepted every cycle.
- reload, when asserted in any state other than S_LEN0:
  - Next state S_LEN0, core_rst_n=0, load_done=0, load_err=0, byte_idx=0, word_count=0.
  - A byte transferred in the same cycle as reload is discarded.
  - Array contents are retained but are unreachable until the next S_RUN.
- instrF:
  - In S_RUN, word index = pcF[ADDR_W+1:2] and pcF[1:0] is ignored.
    - If pcF[31:ADDR_W+2]!=0 or index>=word_count, instrF=NOP_INSTR.
    - Otherwise instrF=mem[index], read with zero latency.
  - In all other states, instrF=NOP_INSTR.
- Write/read collision cannot occur, because reads are only valid in S_RUN where no writes happen.
- Width rules:
  - len is 16 bits, compared after zero-extension against 2**ADDR_W.
  - word_count never exceeds 2**ADDR_W.
- Partial word on reload or reset mid-load: the partial word is dropped and never written.

Test Plan:
- Reset, then stream 02 00 13 05 A0 00 93 05 50 00 → mem[0]=32'h00A00513, mem[1]=32'h00500593.
  - S_RUN on the edge accepting the 10th byte; core_rst_n=1, load_done=1, word_count=2, rx_ready=0 the next cycle.
  - pcF=0 gives instrF=00A00513; pcF=4 gives 00500593; pcF=8 gives 00000013.
- Header 00 00 → load_err=1, rx_ready=0, core_rst_n=0. A reload pulse then clears load_err and returns rx_ready=1.
- With ADDR_W=8, header 01 01 (len=257) → S_ERR. Header 00 01 (len=256) is then accepted and 1024 bytes are loaded.
  - Final word_count=256; pcF=32'h3FC reads the last word; pcF=32'h400 gives NOP.
- rx_valid toggled randomly during a 3-word load → words assembled identically to the back-to-back case; no byte is lost or duplicated.
- reload asserted after 6 data bytes of a 2-word load → word_count=0, S_LEN0, core_rst_n stays 0. A fresh 1-word load then runs with word_count=1.
- Asynchronous rst asserted mid-cycle in S_RUN → core_rst_n=0 and instrF=NOP immediately, without waiting for a clock edge.
